// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for a five-stage in-order core.
//
// Purpose:
//   - Detects load-use hazards between decode and execute and inserts a one-cycle bubble.
//   - Flushes IF/ID and bubbles ID/EX on a taken branch/jump resolved in execute.
//   - Drains the pipeline after a halt reaches execute, then parks in a halted state.
//   - Freezes every pipeline register while data memory is busy.
//   - Selects ALU operand forwarding sources (EX/MEM or MEM/WB over the register file).
//   - Keeps a saturating count of stall cycles spent in normal execution.
//
// Ports:
//   clk, rst                       single clock, synchronous active-high reset
//   idRs/idRt, idUsesRs/idUsesRt   decode-stage sources and their use flags
//   exRs/exRt                      execute-stage sources (forwarding compare)
//   exWriteReg/exRegWrt/exMemToReg execute-stage destination, write enable, load flag
//   exHalt/exDoBranch              halt and taken branch/jump in execute
//   memWriteReg/memRegWrt/memMemToReg  memory-stage destination, write enable, load flag
//   wbWriteReg/wbRegWrt            writeback-stage destination and write enable
//   memBusy                        data memory not ready; freeze the pipeline
//   stallPc/stallIfId/stallIdEx/stallExMem  hold the named register
//   flushIfId/bubbleIdEx           clear IF/ID, inject a NOP into ID/EX
//   fwdASel/fwdBSel                0 = register file, 1 = EX/MEM, 2 = MEM/WB
//   haltDone                       pipeline drained after halt
//   stallCnt                       saturating stall-cycle counter
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  idRs,
  input  logic [2:0]  idRt,
  input  logic        idUsesRs,
  input  logic        idUsesRt,
  input  logic [2:0]  exRs,
  input  logic [2:0]  exRt,
  input  logic [2:0]  exWriteReg,
  input  logic        exRegWrt,
  input  logic        exMemToReg,
  input  logic        exHalt,
  input  logic        exDoBranch,
  input  logic [2:0]  memWriteReg,
  input  logic        memRegWrt,
  input  logic        memMemToReg,
  input  logic [2:0]  wbWriteReg,
  input  logic        wbRegWrt,
  input  logic        memBusy,
  output logic        stallPc,
  output logic        stallIfId,
  output logic        stallIdEx,
  output logic        stallExMem,
  output logic        flushIfId,
  output logic        bubbleIdEx,
  output logic [1:0]  fwdASel,
  output logic [1:0]  fwdBSel,
  output logic        haltDone,
  output logic [15:0] stallCnt
);

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  state_e      stateQ, stateD;
  logic [1:0]  drainQ, drainD;
  logic        luSeenQ, luSeenD;
  logic [15:0] stallCntQ, stallCntD;
  logic        loadUse;

  // Register 0 is an ordinary register: no zero-register exclusion anywhere.
  always_comb begin
    loadUse = exRegWrt & exMemToReg &
              ((idUsesRs & (idRs == exWriteReg)) | (idUsesRt & (idRt == exWriteReg)));
  end

  // Forwarding: EX/MEM wins over MEM/WB; a load in MEM has no result yet.
  always_comb begin
    fwdASel = 2'd0;
    fwdBSel = 2'd0;
    if (memRegWrt & ~memMemToReg & (memWriteReg == exRs)) begin
      fwdASel = 2'd1;
    end else if (wbRegWrt & (wbWriteReg == exRs)) begin
      fwdASel = 2'd2;
    end
    if (memRegWrt & ~memMemToReg & (memWriteReg == exRt)) begin
      fwdBSel = 2'd1;
    end else if (wbRegWrt & (wbWriteReg == exRt)) begin
      fwdBSel = 2'd2;
    end
  end

  always_comb begin
    stateD     = stateQ;
    drainD     = drainQ;
    luSeenD    = luSeenQ;
    stallCntD  = stallCntQ;
    stallPc    = 1'b0;
    stallIfId  = 1'b0;
    stallIdEx  = 1'b0;
    stallExMem = 1'b0;
    flushIfId  = 1'b0;
    bubbleIdEx = 1'b0;

    if (memBusy) begin
      // Freeze: everything holds, so the pending request reappears once memBusy drops.
      stallPc    = 1'b1;
      stallIfId  = 1'b1;
      stallIdEx  = 1'b1;
      stallExMem = 1'b1;
      if ((stateQ == StRun) && (stallCntQ != 16'hFFFF)) begin
        stallCntD = stallCntQ + 16'd1;
      end
    end else begin
      luSeenD = 1'b0;
      unique case (stateQ)
        StRun: begin
          if (exHalt) begin
            // Halt outranks a same-cycle branch.
            flushIfId  = 1'b1;
            bubbleIdEx = 1'b1;
            drainD     = 2'd2;
            stateD     = StDrain;
          end else if (exDoBranch) begin
            flushIfId  = 1'b1;
            bubbleIdEx = 1'b1;
          end else if (loadUse & ~luSeenQ) begin
            // luSeenQ limits the stall to one cycle even if EX is not refreshed.
            stallPc    = 1'b1;
            stallIfId  = 1'b1;
            bubbleIdEx = 1'b1;
            luSeenD    = 1'b1;
            if (stallCntQ != 16'hFFFF) begin
              stallCntD = stallCntQ + 16'd1;
            end
          end
        end
        StDrain: begin
          stallPc    = 1'b1;
          bubbleIdEx = 1'b1;
          drainD     = drainQ - 2'd1;
          if (drainQ <= 2'd1) begin
            drainD = 2'd0;
            stateD = StHalted;
          end
        end
        StHalted: begin
          stallPc    = 1'b1;
          stallIfId  = 1'b1;
          bubbleIdEx = 1'b1;
        end
        default: begin
          stateD = StRun;
        end
      endcase
    end
  end

  always_comb begin
    haltDone = (stateQ == StHalted);
    stallCnt = stallCntQ;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ    <= StRun;
      drainQ    <= 2'd0;
      luSeenQ   <= 1'b0;
      stallCntQ <= 16'd0;
    end else begin
      stateQ    <= stateD;
      drainQ    <= drainD;
      luSeenQ   <= luSeenD;
      stallCntQ <= stallCntD;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random stimulus,
// all compared against a behavioural model of pipeline mode, drain length and stall count.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [2:0]  idRs, idRt, exRs, exRt, exWriteReg, memWriteReg, wbWriteReg;
  logic        idUsesRs, idUsesRt, exRegWrt, exMemToReg, exHalt, exDoBranch;
  logic        memRegWrt, memMemToReg, wbRegWrt, memBusy;
  logic        stallPc, stallIfId, stallIdEx, stallExMem, flushIfId, bubbleIdEx, haltDone;
  logic [1:0]  fwdASel, fwdBSel;
  logic [15:0] stallCnt;

  int checks = 0;
  int errors = 0;

  // Model: mode 0 = running, 1 = draining, 2 = halted.
  int mMode  = 0;
  int mDrain = 0;
  int mCnt   = 0;
  bit mSup   = 0;
  bit modelValid = 0;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .idRs(idRs), .idRt(idRt), .idUsesRs(idUsesRs), .idUsesRt(idUsesRt),
    .exRs(exRs), .exRt(exRt), .exWriteReg(exWriteReg), .exRegWrt(exRegWrt),
    .exMemToReg(exMemToReg), .exHalt(exHalt), .exDoBranch(exDoBranch),
    .memWriteReg(memWriteReg), .memRegWrt(memRegWrt), .memMemToReg(memMemToReg),
    .wbWriteReg(wbWriteReg), .wbRegWrt(wbRegWrt), .memBusy(memBusy),
    .stallPc(stallPc), .stallIfId(stallIfId), .stallIdEx(stallIdEx),
    .stallExMem(stallExMem), .flushIfId(flushIfId), .bubbleIdEx(bubbleIdEx),
    .fwdASel(fwdASel), .fwdBSel(fwdBSel), .haltDone(haltDone), .stallCnt(stallCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearIn();
    rst = 0; idRs = 0; idRt = 0; idUsesRs = 0; idUsesRt = 0; exRs = 0; exRt = 0;
    exWriteReg = 0; exRegWrt = 0; exMemToReg = 0; exHalt = 0; exDoBranch = 0;
    memWriteReg = 0; memRegWrt = 0; memMemToReg = 0; wbWriteReg = 0; wbRegWrt = 0;
    memBusy = 0;
  endtask

  function automatic logic [1:0] fwdRef(input logic [2:0] src);
    if (memRegWrt && !memMemToReg && memWriteReg == src) return 2'd1;
    if (wbRegWrt && wbWriteReg == src) return 2'd2;
    return 2'd0;
  endfunction

  // One clock: check outputs against the model, then advance model at the edge.
  task automatic step();
    logic [6:0] eCtl;
    bit lu, luStall;
    #1;
    lu = exRegWrt && exMemToReg &&
         ((idUsesRs && idRs == exWriteReg) || (idUsesRt && idRt == exWriteReg));
    luStall = 0;
    eCtl = 7'b0;
    // {stallPc, stallIfId, stallIdEx, stallExMem, flushIfId, bubbleIdEx, haltDone}
    if (memBusy) eCtl = 7'b1111000;
    else if (mMode == 0) begin
      if (exHalt || exDoBranch) eCtl = 7'b0000110;
      else if (lu && !mSup) begin eCtl = 7'b1100010; luStall = 1; end
    end else if (mMode == 1) eCtl = 7'b1000010;
    else eCtl = 7'b1100010;
    if (mMode == 2) eCtl[0] = 1'b1;
    if (modelValid) begin
      chk("ctl", {9'd0, stallPc, stallIfId, stallIdEx, stallExMem, flushIfId, bubbleIdEx,
                  haltDone}, {9'd0, eCtl});
      chk("fwdA", {14'd0, fwdASel}, {14'd0, fwdRef(exRs)});
      chk("fwdB", {14'd0, fwdBSel}, {14'd0, fwdRef(exRt)});
      chk("stallCnt", stallCnt, mCnt[15:0]);
    end
    @(posedge clk);
    if (rst) begin
      mMode = 0; mDrain = 0; mCnt = 0; mSup = 0;
    end else begin
      if (mMode == 0 && eCtl[6] && mCnt < 65535) mCnt++;
      if (!memBusy) begin
        mSup = luStall;
        if (mMode == 0 && exHalt) begin mMode = 1; mDrain = 2; end
        else if (mMode == 1) begin
          mDrain--;
          if (mDrain == 0) mMode = 2;
        end
      end
    end
    #1;
  endtask

  initial begin
    clearIn();
    rst = 1;
    @(posedge clk);
    #1;
    step();
    modelValid = 1;
    rst = 0;
    #1;
    chk("rst_ctl", {10'd0, stallPc, stallIfId, stallIdEx, stallExMem, flushIfId, bubbleIdEx},
        16'd0);
    chk("rst_cnt", stallCnt, 16'd0);
    chk("rst_halt", {15'd0, haltDone}, 16'd0);
    step();

    // Load-use on r3, then forwarding once the load reaches writeback.
    exWriteReg = 3; exRegWrt = 1; exMemToReg = 1; idRs = 3; idUsesRs = 1;
    #1;
    chk("lu_stall", {13'd0, stallPc, stallIfId, bubbleIdEx}, 16'h7);
    step();
    exRegWrt = 0; exMemToReg = 0; exRs = 3;
    memWriteReg = 3; memRegWrt = 1; memMemToReg = 1;
    #1;
    chk("lu_nostall", {15'd0, stallPc}, 16'd0);
    step();
    memRegWrt = 0; memMemToReg = 0; wbWriteReg = 3; wbRegWrt = 1;
    #1;
    chk("lu_fwd_wb", {14'd0, fwdASel}, 16'd2);
    chk("lu_cnt", stallCnt, 16'd1);
    step();

    // Both forwarding sources on r5: EX/MEM wins; dropping it falls back to MEM/WB.
    clearIn();
    memWriteReg = 5; wbWriteReg = 5; memRegWrt = 1; wbRegWrt = 1; exRs = 5; exRt = 5;
    #1;
    chk("fwd_mem", {12'd0, fwdASel, fwdBSel}, 16'h5);
    step();
    memRegWrt = 0;
    #1;
    chk("fwd_wb", {12'd0, fwdASel, fwdBSel}, 16'hA);
    step();

    // Branch together with load-use: flush wins, no stall, count unchanged.
    clearIn();
    exWriteReg = 0; exRegWrt = 1; exMemToReg = 1; idRt = 0; idUsesRt = 1; exDoBranch = 1;
    #1;
    chk("br_ctl", {13'd0, flushIfId, bubbleIdEx, stallPc}, 16'h6);
    step();
    clearIn();
    #1;
    chk("br_cnt", stallCnt, 16'd1);
    rst = 1;
    step();
    rst = 0;

    // Freeze for three cycles over a pending branch.
    exDoBranch = 1; memBusy = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("frz_ctl", {12'd0, stallPc, stallIfId, stallIdEx, stallExMem, flushIfId,
                      bubbleIdEx}, 16'h3C);
      step();
    end
    memBusy = 0;
    #1;
    chk("frz_flush", {15'd0, flushIfId}, 16'd1);
    chk("frz_cnt", stallCnt, 16'd3);
    step();

    // Halt, two drain cycles, ten halted cycles, then reset back to running.
    clearIn();
    exHalt = 1; exDoBranch = 1;
    #1;
    chk("halt_flush", {14'd0, flushIfId, stallPc}, 16'h2);
    step();
    clearIn();
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("drain", {14'd0, stallPc, haltDone}, 16'h2);
      step();
    end
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("halted", {15'd0, haltDone}, 16'd1);
      step();
    end
    rst = 1;
    step();
    rst = 0;
    #1;
    chk("halt_rst", {14'd0, haltDone, stallPc}, 16'd0);
    chk("halt_rst_cnt", stallCnt, 16'd0);
    step();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 39) == 0);
      idRs        = 3'($urandom_range(0, 3));
      idRt        = 3'($urandom_range(0, 3));
      idUsesRs    = 1'($urandom);
      idUsesRt    = 1'($urandom);
      exRs        = 3'($urandom_range(0, 3));
      exRt        = 3'($urandom_range(0, 3));
      exWriteReg  = 3'($urandom_range(0, 3));
      exRegWrt    = 1'($urandom);
      exMemToReg  = 1'($urandom);
      exHalt      = ($urandom_range(0, 31) == 0);
      exDoBranch  = ($urandom_range(0, 3) == 0);
      memWriteReg = 3'($urandom_range(0, 3));
      memRegWrt   = 1'($urandom);
      memMemToReg = 1'($urandom);
      wbWriteReg  = 3'($urandom_range(0, 3));
      wbRegWrt    = 1'($urandom);
      memBusy     = ($urandom_range(0, 7) == 0);
      step();
    end

    // Counter saturation.
    clearIn();
    rst = 1;
    step();
    rst = 0;
    memBusy = 1;
    for (int i = 0; i < 65535; i++) step();
    #1;
    chk("sat_full", stallCnt, 16'hFFFF);
    step();
    #1;
    chk("sat_hold", stallCnt, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
